uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- Frame controller and serializer for the UART transmit path; sits directly downstream of parity_gen.
- Accepts a parallel byte and latches it, then drives the latched byte and parity type to parity_gen.
- Serializes one frame on tx_out: start bit, LSB-first data, optional parity bit (taken from parity_gen's par_bit), then stop bit.
- One bit per clock; baud-rate pacing is handled by the clock enable/clock source outside this block.

Parameters:
- data_width, 8, number of data bits per frame (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- p_data  input  data_width  byte to transmit; sampled only on accept.
- data_valid  input  1  request to send p_data.
- par_en  input  1  1 = frame includes a parity bit; sampled on accept.
- par_typ  input  1  0 = even, 1 = odd; sampled on accept.
- par_bit  input  1  registered parity from parity_gen, computed over frame_data.
- frame_data  output  data_width  latched byte; drives parity_gen p_data.
- frame_par_typ  output  1  latched parity type; drives parity_gen par_typ.
- tx_out  output  1  serial line, idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, tx_out=1, busy=0.
  - frame_data=0, frame_par_typ=0, par_en latch=0, bit counter=0.
- Reset release is synchronous to clk. Reset mid-frame aborts the frame immediately; tx_out returns high in the same instant.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - At an edge with data_valid=1: latch p_data into frame_data; latch par_typ and par_en; go to START.
  - tx_out=0 and busy=1 from that same edge. Acceptance latency: 0 cycles after the accepting edge.
- START: one cycle, tx_out=0. Then go to DATA with the counter at 0.
- DATA:
  - data_width cycles; tx_out=frame_data[counter], LSB first.
  - Counter increments each cycle and wraps to 0 on leaving DATA.
  - After bit data_width-1: go to PARITY if the latched par_en=1, else STOP.
- PARITY:
  - One cycle; tx_out=par_bit.
  - par_bit is guaranteed valid because parity_gen has had at least data_width+1 cycles of stable frame_data.
- STOP: one cycle, tx_out=1, busy=1.
- At the STOP exit edge:
  - data_valid=1: accept new data and go straight to START, giving back-to-back frames with no idle gap.
  - Otherwise go to IDLE, where busy=0.
- data_valid is ignored in START/DATA/PARITY. p_data/par_en/par_typ changes during a frame do not affect it.
- frame_data and frame_par_typ hold their values after the frame until the next accept.
- Frame length:
  - 1 + data_width + 1 + 1 cycles with parity (11 at default).
  - 10 cycles without parity at default.

Optional Feature:
- UART_TX_TWO_STOP_EN:
  - Defined: STOP lasts two cycles (tx_out=1 for both). A back-to-back accept is evaluated only at the exit edge of the second stop cycle. Frame length grows by 1.
  - Undefined: exactly one stop cycle, as described above.

Test Plan:
- Reset: hold rst=0 with data_valid=1 and p_data=8'hAB -> tx_out=1, busy=0, frame_data=8'h00. Assert rst=0 mid-DATA -> tx_out=1 and busy=0 immediately.
- Even parity, even ones: p_data=8'hA9, par_en=1, par_typ=0 -> tx_out sequence 0,1,0,0,1,0,1,0,1,0,1 across 11 cycles (start, data LSB-first, parity=0, stop), then busy=0.
- Even parity, odd ones: p_data=8'hAD, par_typ=0 -> parity cycle tx_out=1. Same byte with par_typ=1 -> parity cycle tx_out=0.
- No parity: p_data=8'h55, par_en=0 -> 10-cycle frame 0,1,0,1,0,1,0,1,0,1; no parity cycle.
- Back-to-back: data_valid held high with p_data=8'h0F then 8'hF0 presented during the first STOP -> second start bit on the cycle right after the first stop. busy stays 1 throughout; frame_data=8'hF0.
- Mid-frame input change: change p_data to 8'hFF and par_typ during DATA -> transmitted bits and parity still match the originally latched byte and type.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit frame controller/serializer (start, LSB-first data, optional parity, stop).
// Define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx_frame #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  par_bit,
  output logic [data_width-1:0] frame_data,
  output logic                  frame_par_typ,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int cw = (data_width > 2) ? $clog2(data_width) : 1;
`ifdef UART_TX_TWO_STOP_EN
  localparam logic two_stop = 1'b1;
`else
  localparam logic two_stop = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [cw-1:0]         cnt_q, cnt_d;
  logic [data_width-1:0] frame_data_q, frame_data_d;
  logic                  frame_par_typ_q, frame_par_typ_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  last_stop;
  assign last_stop     = !two_stop || cnt_q == cw'(1);
  assign frame_data    = frame_data_q;
  assign frame_par_typ = frame_par_typ_q;
  assign tx_out        = tx_out_q;
  assign busy          = busy_q;
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    frame_data_d    = frame_data_q;
    frame_par_typ_d = frame_par_typ_q;
    par_en_d        = par_en_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        cnt_d   = (cnt_q == cw'(data_width - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q != cw'(data_width - 1)) ? DATA : par_en_q ? PARITY : STOP;
      end
      PARITY:  state_d = STOP;
      STOP: begin
        cnt_d   = last_stop ? '0 : cw'(1);
        state_d = last_stop ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    // A new byte is taken only when the line is idle or at the final stop edge.
    if (data_valid && (state_q == IDLE || (state_q == STOP && last_stop))) begin
      state_d         = START;
      cnt_d           = '0;
      frame_data_d    = p_data;
      frame_par_typ_d = par_typ;
      par_en_d        = par_en;
    end
    tx_out_d = (state_d == START) ? 1'b0 :
               (state_d == DATA)   ? frame_data_d[cnt_d] :
               (state_d == PARITY) ? par_bit : 1'b1;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      frame_data_q    <= '0;
      frame_par_typ_q <= 1'b0;
      par_en_q        <= 1'b0;
      tx_out_q        <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      frame_data_q    <= frame_data_d;
      frame_par_typ_q <= frame_par_typ_d;
      par_en_q        <= par_en_d;
      tx_out_q        <= tx_out_d;
      busy_q          <= busy_d;
    end
  end
endmodule
